// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Shared definitions for the program-counter sequencer.
//   state_t      : sequencer states (RUN, ISR, FAULT)
//   DEF_AW       : default program-address width
//   DEF_IRQ_VEC  : default interrupt entry address
// -----------------------------------------------------------------------------
package pc_seq_pkg;

    localparam int          DEF_AW      = 16;
    localparam logic [15:0] DEF_IRQ_VEC = 16'h0004;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ISR   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/pc_seq_ret_stack.sv
// -----------------------------------------------------------------------------
// pc_ret_stack
// Return-address stack: DEPTH entries of AW bits, with an occupancy counter.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (clears occupancy only)
//   i_push     : write i_data at index sp, sp+1 (ignored when full)
//   i_pop      : sp-1 (ignored when empty); o_top shows the entry being popped
//   i_data     : value to push
//   o_top      : entry at index sp-1 (don't-care when empty)
//   o_sp       : occupancy 0..DEPTH
//   o_full     : sp == DEPTH
//   o_empty    : sp == 0
// The entry array is deliberately not reset: only entries below sp carry
// meaning, so clearing sp is enough to discard the whole stack.
// -----------------------------------------------------------------------------
module pc_ret_stack #(
    parameter int AW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [AW-1:0]          i_data,
    output logic [AW-1:0]          o_top,
    output logic [$clog2(DEPTH):0] o_sp,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int         IW      = $clog2(DEPTH);
    localparam logic [IW:0] SP_ONE  = (IW+1)'(1);
    localparam logic [IW:0] SP_FULL = (IW+1)'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [IW:0]   r_sp;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_top_idx;
    logic          w_do_push;
    logic          w_do_pop;

    // DEPTH is a power of two, so the low bits of sp address the array
    // directly; when full they wrap to 0, which is never written (push is
    // blocked) and the top index wraps correctly to DEPTH-1.
    assign w_wr_idx  = r_sp[IW-1:0];
    assign w_top_idx = r_sp[IW-1:0] - IW'(1);

    assign o_full    = (r_sp == SP_FULL);
    assign o_empty   = (r_sp == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty && !i_push;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + SP_ONE;
        end else if (w_do_pop) begin
            r_sp <= r_sp - SP_ONE;
        end
    end

    assign o_top = r_mem[w_top_idx];
    assign o_sp  = r_sp;

endmodule

// File: rtl/pc_seq.sv
// -----------------------------------------------------------------------------
// pc_seq
// Program-counter sequencer with a return stack and an optional interrupt.
// Optional feature macro: PC_SEQ_IRQ_EN (adds the irq port and the ISR state).
// Ports:
//   clk     : clock, all state updates on the rising edge
//   rst     : asynchronous active-high reset (pc=0, sp=0, state RUN)
//   stall   : hold everything; requests in a stalled cycle are dropped
//   bra     : load pc from target
//   call    : push pc+1, load pc from target
//   ret     : pop the stack into pc
//   target  : branch/call destination
//   irq     : level interrupt request (PC_SEQ_IRQ_EN only)
//   pc      : current program address
//   sp      : stack occupancy 0..DEPTH
//   fault   : high in FAULT (left only by rst)
//   in_isr  : high in ISR (tied 0 without PC_SEQ_IRQ_EN)
// Priority per active cycle: irq entry > ret > call > bra > pc+1.
// -----------------------------------------------------------------------------
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int            AW      = DEF_AW,
    parameter int            DEPTH   = 8,
    parameter logic [AW-1:0] IRQ_VEC = AW'(DEF_IRQ_VEC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   bra,
    input  logic                   call,
    input  logic                   ret,
    input  logic [AW-1:0]          target,
`ifdef PC_SEQ_IRQ_EN
    input  logic                   irq,
`endif
    output logic [AW-1:0]          pc,
    output logic [$clog2(DEPTH):0] sp,
    output logic                   fault,
    output logic                   in_isr
);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [AW-1:0]          r_pc;
    logic [AW-1:0]          w_pc_next;
    logic [AW-1:0]          w_pc_inc;
    logic [AW-1:0]          w_push_data;
    logic [AW-1:0]          w_top;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_irq_take;
    logic [$clog2(DEPTH):0] w_sp;

    assign w_pc_inc = r_pc + AW'(1);

    // Interrupt entry is only possible from RUN: no nesting inside ISR.
`ifdef PC_SEQ_IRQ_EN
    assign w_irq_take = irq && (r_state == ST_RUN);
`else
    assign w_irq_take = 1'b0;
`endif

    pc_ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_push_data),
        .o_top   (w_top),
        .o_sp    (w_sp),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_push_data  = w_pc_inc;

        if (!stall && (r_state != ST_FAULT)) begin
            if (w_irq_take) begin
                // Push the pre-empted address itself so ret resumes it.
                if (w_full) begin
                    w_state_next = ST_FAULT;
                end else begin
                    w_push       = 1'b1;
                    w_push_data  = r_pc;
                    w_pc_next    = IRQ_VEC;
                    w_state_next = ST_ISR;
                end
            end else if (ret) begin
                if (w_empty) begin
                    w_state_next = ST_FAULT;
                end else begin
                    w_pop     = 1'b1;
                    w_pc_next = w_top;
                    if (r_state == ST_ISR) begin
                        w_state_next = ST_RUN;
                    end
                end
            end else if (call) begin
                if (w_full) begin
                    w_state_next = ST_FAULT;
                end else begin
                    w_push    = 1'b1;
                    w_pc_next = target;
                end
            end else if (bra) begin
                w_pc_next = target;
            end else begin
                w_pc_next = w_pc_inc;
            end
        end
    end

    assign pc    = r_pc;
    assign sp    = w_sp;
    assign fault = (r_state == ST_FAULT);

`ifdef PC_SEQ_IRQ_EN
    assign in_isr = (r_state == ST_ISR);
`else
    assign in_isr = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq.sv
// -----------------------------------------------------------------------------
// tb_pc_seq
// Bench for pc_seq: directed scenarios with literal expectations, then
// randomized stimulus. A queue-based reference model tracks pc, the return
// stack, fault and ISR status; a compare process checks the DUT against it on
// every falling edge. Define PC_SEQ_IRQ_EN to exercise the interrupt path.
// -----------------------------------------------------------------------------
module tb_pc_seq;

    localparam int          AW      = 16;
    localparam int          DEPTH   = 8;
    localparam logic [15:0] IRQ_VEC = 16'h0004;
`ifdef PC_SEQ_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk    = 1'b0;
    logic        rst    = 1'b0;
    logic        stall  = 1'b0;
    logic        bra    = 1'b0;
    logic        call   = 1'b0;
    logic        ret    = 1'b0;
    logic        irq    = 1'b0;
    logic [15:0] target = '0;
    logic [15:0] pc;
    logic [3:0]  sp;
    logic        fault;
    logic        in_isr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    bit          m_fault;
    bit          m_isr;

    always #5 clk = ~clk;

    pc_seq #(
        .AW      (AW),
        .DEPTH   (DEPTH),
        .IRQ_VEC (IRQ_VEC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .stall  (stall),
        .bra    (bra),
        .call   (call),
        .ret    (ret),
        .target (target),
`ifdef PC_SEQ_IRQ_EN
        .irq    (irq),
`endif
        .pc     (pc),
        .sp     (sp),
        .fault  (fault),
        .in_isr (in_isr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0;
        m_stk.delete();
        m_fault = 1'b0;
        m_isr = 1'b0;
    endtask

    // One accepted edge, straight from the behavioural rules.
    task automatic model_step();
        if (stall || m_fault) return;
        if (IRQ_EN && irq && !m_isr) begin
            if (m_stk.size() == DEPTH) m_fault = 1'b1;
            else begin
                m_stk.push_back(m_pc);
                m_pc = IRQ_VEC;
                m_isr = 1'b1;
            end
        end else if (ret) begin
            if (m_stk.size() == 0) m_fault = 1'b1;
            else begin
                m_pc = m_stk.pop_back();
                m_isr = 1'b0;
            end
        end else if (call) begin
            if (m_stk.size() == DEPTH) m_fault = 1'b1;
            else begin
                m_stk.push_back(m_pc + 16'd1);
                m_pc = target;
            end
        end else if (bra) begin
            m_pc = target;
        end else begin
            m_pc = m_pc + 16'd1;
        end
    endtask

    // Called at negedge+1; drives one cycle's requests, returns at next negedge+1.
    task automatic cyc(input bit b, input bit c, input bit r, input bit s,
                       input bit i, input logic [15:0] t);
        bra = b; call = c; ret = r; stall = s; irq = i; target = t;
        @(posedge clk);
        if (!rst) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // Asynchronous reset asserted and released away from the clock edges.
    task automatic do_reset();
        bra = 1'b0; call = 1'b0; ret = 1'b0; stall = 1'b0; irq = 1'b0;
        #1;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Continuous compare against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("pc_model", pc, m_pc);
                chk("sp_model", sp, m_stk.size());
                chk("fault_model", fault, m_fault);
                chk("in_isr_model", in_isr, m_isr);
            end
        end
    end

    initial begin
        logic [15:0] t;
        model_reset();
        @(negedge clk);
        #1;
        do_reset();
        chk_en = 1'b1;

        // Reset state and sequential counting
        chk("rst_pc", pc, 0);
        chk("rst_sp", sp, 0);
        chk("rst_fault", fault, 0);
        chk("rst_in_isr", in_isr, 0);
        for (int i = 1; i <= 5; i++) begin
            idle();
            chk("seq_pc", pc, i);
        end
        chk("seq_sp", sp, 0);

        // Wrap at the top of the address space
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF);
        chk("wrap_pre", pc, 16'hFFFF);
        idle();
        chk("wrap_post", pc, 16'h0000);

        // call / ret round trip
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd10);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd100);
        chk("call_pc", pc, 100);
        chk("call_sp", sp, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("ret_pc", pc, 11);
        chk("ret_sp", sp, 0);

        // bra+call+ret together: ret wins
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h001F);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0040);
        chk("prio_setup_sp", sp, 1);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0077);
        chk("prio_pc", pc, 16'h0020);
        chk("prio_sp", sp, 0);

        // Overflow into FAULT, frozen until reset
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100 + 16'(i));
        chk("full_sp", sp, DEPTH);
        chk("full_fault", fault, 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0999);
        chk("ovf_fault", fault, 1);
        chk("ovf_pc", pc, 16'h0107);
        chk("ovf_sp", sp, DEPTH);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0555);
        chk("fault_bra_ignored", pc, 16'h0107);
        do_reset();
        chk("fault_rst_pc", pc, 0);
        chk("fault_rst_fault", fault, 0);

        // Underflow into FAULT
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("unf_fault", fault, 1);
        chk("unf_pc", pc, 0);
        do_reset();

        // Stall holds and drops the pending branch
        idle();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0333);
        chk("stall_pc", pc, 1);
        idle();
        chk("stall_dropped", pc, 2);

`ifdef PC_SEQ_IRQ_EN
        // Interrupt entry, no re-entry while held, return
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd50);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("irq_pc", pc, 16'h0004);
        chk("irq_in_isr", in_isr, 1);
        chk("irq_sp", sp, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        chk("irq_nonest_pc", pc, 16'h0005);
        chk("irq_nonest_sp", sp, 1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("isr_ret_pc", pc, 50);
        chk("isr_ret_in_isr", in_isr, 0);
        chk("isr_ret_sp", sp, 0);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ((m_fault && ($urandom_range(0, 5) == 0)) || ($urandom_range(0, 299) == 0)) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 3) == 0) t = 16'hFFF0 + 16'($urandom_range(0, 15));
                else t = 16'($urandom_range(0, 65535));
                cyc($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 15,
                    $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
                    IRQ_EN && ($urandom_range(0, 99) < 10), t);
            end
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
